// File: rtl/fp_issue_sequencer_if.sv
// rtl/fp_issue_sequencer_if.sv - Execute-stage FP issue / FPU hand-off signal bundle
interface fp_issue_sequencer_if;
  logic        IsFpE;
  logic [1:0]  FpOpE;
  logic        KillE;
  logic [31:0] FpuResult;
  logic [4:0]  FpuFlags;
  logic        FpuStart;
  logic [1:0]  FpuOp;
  logic        StallFp;
  logic        FpBusy;
  logic        FpResultValidM;
  logic [31:0] FpResultM;
  logic [4:0]  FpFlagsM;

  // The sequencer itself sits on the slave side.
  modport slave (
    input  IsFpE, FpOpE, KillE, FpuResult, FpuFlags,
    output FpuStart, FpuOp, StallFp, FpBusy, FpResultValidM, FpResultM, FpFlagsM
  );

  modport master (
    output IsFpE, FpOpE, KillE, FpuResult, FpuFlags,
    input  FpuStart, FpuOp, StallFp, FpBusy, FpResultValidM, FpResultM, FpFlagsM
  );
endinterface

// File: rtl/fp_issue_sequencer.sv
// rtl/fp_issue_sequencer.sv - issues FADD/FSUB/FMUL/FDIV, counts latency, stalls F/D/E, registers result for Memory
module fp_issue_sequencer #(
  parameter int LAT_ADD = 2,
  parameter int LAT_SUB = 2,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 16,
  parameter int CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_issue_sequencer_if.slave  bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [31:0]      r_res;
  logic [4:0]       r_flags;
  logic             r_valid;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_op_nxt;
  logic             w_capture;
  logic             w_issue;
  logic [CNT_W-1:0] w_lat;

  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] op);
    case (op)
      2'b00:   lat_of = CNT_W'(LAT_ADD);
      2'b01:   lat_of = CNT_W'(LAT_SUB);
      2'b10:   lat_of = CNT_W'(LAT_MUL);
      default: lat_of = CNT_W'(LAT_DIV);
    endcase
  endfunction

  // Gated by reset so a held IsFpE cannot launch the unit while reset is asserted.
  assign w_issue = bus.IsFpE & ~bus.KillE & reset;
  assign w_lat   = lat_of(bus.FpOpE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_valid <= w_capture;
      if (w_capture) begin
        r_res   <= bus.FpuResult;
        r_flags <= bus.FpuFlags;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          if (w_lat <= C_ONE) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = w_lat - C_ONE;
            w_op_nxt    = bus.FpOpE;
          end
        end
      end
      S_BUSY: begin
        // A redirect beats completion: the result is dropped, never captured.
        if (bus.KillE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= C_ONE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    bus.FpuStart = 1'b0;
    bus.FpuOp    = r_op;
    bus.StallFp  = 1'b0;
    bus.FpBusy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          bus.FpuStart = 1'b1;
          bus.FpuOp    = bus.FpOpE;
          bus.StallFp  = (w_lat > C_ONE);
        end
      end
      S_BUSY: begin
        bus.FpBusy  = 1'b1;
        bus.StallFp = ~bus.KillE & (r_cnt > C_ONE);
      end
      default: ;
    endcase
  end

  assign bus.FpResultValidM = r_valid;
  assign bus.FpResultM      = r_res;
  assign bus.FpFlagsM       = r_flags;

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// tb/tb_fp_issue_sequencer.sv - randomized self-checking bench for fp_issue_sequencer
module tb_fp_issue_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        is_fp = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  fp_op = 2'b00;
  logic [31:0] fpu_res = '0;
  logic [4:0]  fpu_flags = '0;

  fp_issue_sequencer_if if0();
  fp_issue_sequencer_if if1();

  assign if0.IsFpE = is_fp;     assign if1.IsFpE = is_fp;
  assign if0.FpOpE = fp_op;     assign if1.FpOpE = fp_op;
  assign if0.KillE = kill;      assign if1.KillE = kill;
  assign if0.FpuResult = fpu_res;   assign if1.FpuResult = fpu_res;
  assign if0.FpuFlags = fpu_flags;  assign if1.FpuFlags = fpu_flags;

  fp_issue_sequencer #(.LAT_ADD(2), .LAT_SUB(2), .LAT_MUL(4), .LAT_DIV(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .bus(if0.slave));
  fp_issue_sequencer #(.LAT_ADD(1), .LAT_SUB(2), .LAT_MUL(4), .LAT_DIV(16), .CNT_W(5)) dut_l1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit alt = 1'b0;
  bit pend_v = 1'b0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_flags = '0;

  wire        o_start = alt ? if1.FpuStart       : if0.FpuStart;
  wire [1:0]  o_op    = alt ? if1.FpuOp          : if0.FpuOp;
  wire        o_stall = alt ? if1.StallFp        : if0.StallFp;
  wire        o_busy  = alt ? if1.FpBusy         : if0.FpBusy;
  wire        o_valid = alt ? if1.FpResultValidM : if0.FpResultValidM;
  wire [31:0] o_res   = alt ? if1.FpResultM      : if0.FpResultM;
  wire [4:0]  o_flags = alt ? if1.FpFlagsM       : if0.FpFlagsM;

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b00:   return alt ? 1 : 2;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 16;
    endcase
  endfunction

  // One instruction in E: cycles 1..L (or until the kill cycle). kill_at=0 means no kill.
  task automatic run_op(input logic [1:0] op, input int kill_at);
    int  l = lat_of(op);
    bit  issued = (kill_at != 1);
    int  last = (kill_at >= 1 && kill_at <= l) ? kill_at : l;
    bit  cap;
    for (int c = 1; c <= last; c++) begin
      is_fp = 1'b1;
      fp_op = op;
      kill = (c == kill_at);
      fpu_res = $urandom;
      fpu_flags = 5'($urandom);
      @(negedge clk);
      checks += 6;
      if (o_start !== ((c == 1) && issued)) begin
        errors++; $display("FAIL start op%0d c%0d: got %b want %b", op, c, o_start, (c == 1) && issued);
      end
      if (o_stall !== (issued && c < l && c != kill_at)) begin
        errors++; $display("FAIL stall op%0d c%0d: got %b want %b", op, c, o_stall, issued && c < l && c != kill_at);
      end
      if (o_busy !== (issued && c >= 2)) begin
        errors++; $display("FAIL busy op%0d c%0d: got %b want %b", op, c, o_busy, issued && c >= 2);
      end
      if (o_valid !== pend_v) begin
        errors++; $display("FAIL valid op%0d c%0d: got %b want %b", op, c, o_valid, pend_v);
      end
      if (o_res !== exp_res) begin
        errors++; $display("FAIL result op%0d c%0d: got %h want %h", op, c, o_res, exp_res);
      end
      if (o_flags !== exp_flags) begin
        errors++; $display("FAIL flags op%0d c%0d: got %b want %b", op, c, o_flags, exp_flags);
      end
      if (issued) begin
        checks++;
        if (o_op !== op) begin
          errors++; $display("FAIL fpuop op%0d c%0d: got %b want %b", op, c, o_op, op);
        end
      end
      cap = issued && (c == l) && (c != kill_at);
      pend_v = cap;
      if (cap) begin
        exp_res = fpu_res;
        exp_flags = fpu_flags;
      end
      @(posedge clk); #1;
    end
    kill = 1'b0;
  endtask

  // A cycle with no issuable instruction in E (non-FP, or FP suppressed by KillE).
  task automatic idle_cycle();
    is_fp = 1'($urandom);
    kill = is_fp;
    fp_op = 2'($urandom);
    fpu_res = $urandom;
    @(negedge clk);
    checks += 5;
    if (o_start !== 1'b0) begin errors++; $display("FAIL idle_start: got %b want 0", o_start); end
    if (o_stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b want 0", o_stall); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", o_busy); end
    if (o_valid !== pend_v) begin errors++; $display("FAIL idle_valid: got %b want %b", o_valid, pend_v); end
    if (o_res !== exp_res) begin errors++; $display("FAIL idle_result: got %h want %h", o_res, exp_res); end
    pend_v = 1'b0;
    @(posedge clk); #1;
    is_fp = 1'b0;
    kill = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    pend_v = 1'b0;
    exp_res = '0;
    exp_flags = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    is_fp = 1'b1;
    fp_op = 2'b00;
    repeat (2) @(negedge clk);
    checks += 6;
    if (o_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", o_start); end
    if (o_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", o_stall); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    if (o_res !== 32'h0) begin errors++; $display("FAIL rst_result: got %h want 0", o_res); end
    if (o_op !== 2'b00) begin errors++; $display("FAIL rst_fpuop: got %b want 00", o_op); end
    @(posedge clk); #1;
    reset = 1'b1;
    pend_v = 1'b0;
    exp_res = '0;
    exp_flags = '0;
    run_op(2'b00, 0);
    idle_cycle();
  endtask

  task automatic test_single_ops();
    run_op(2'b00, 0); idle_cycle();
    run_op(2'b11, 0); idle_cycle();
    run_op(2'b01, 0); idle_cycle();
    run_op(2'b10, 0); idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_op(2'b10, 0);
    run_op(2'b01, 0);
    run_op(2'b11, 0);
    run_op(2'b00, 0);
    idle_cycle();
  endtask

  task automatic test_kill();
    run_op(2'b00, 0);
    run_op(2'b10, 3);
    idle_cycle();
    idle_cycle();
    run_op(2'b11, 16);
    idle_cycle();
    run_op(2'b01, 1);
    run_op(2'b01, 0);
    idle_cycle();
  endtask

  task automatic test_reset_mid_busy();
    is_fp = 1'b1;
    fp_op = 2'b11;
    kill = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    checks += 5;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
    if (o_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", o_stall); end
    if (o_start !== 1'b0) begin errors++; $display("FAIL midrst_start: got %b want 0", o_start); end
    if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
    if (o_res !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 0", o_res); end
    @(posedge clk); #1;
    reset = 1'b1;
    is_fp = 1'b0;
    pend_v = 1'b0;
    exp_res = '0;
    exp_flags = '0;
    repeat (3) idle_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op = 2'($urandom);
      int k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat_of(op)) : 0;
      run_op(op, k);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_lat1();
    alt = 1'b1;
    do_reset();
    run_op(2'b00, 0);
    idle_cycle();
    run_op(2'b00, 0);
    run_op(2'b00, 0);
    run_op(2'b10, 0);
    run_op(2'b00, 1);
    idle_cycle();
    alt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_kill();
    test_reset_mid_busy();
    test_random();
    test_lat1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
